bus_rr_matrix: RTL and testbench

- Parametrised successor of the 2-master/5-slave system bus: N_MASTER masters share one slave-side channel and fan out to N_SLAVE slaves.
- Arbitration is round-robin with an optional hold limit, replacing fixed m0 priority.
- Slave selection comes from a parameterised address-field decode; read data is returned through a one-cycle registered select.
- Sits between the CPU/DMA masters and the memory/peripheral slaves in the arithmetic and logical computing system top.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 73 +++++++
 rtl/bus_rr_matrix.sv | 91 +++++++++
 tb/tb_bus_rr_matrix.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the multi-master system bus: default widths,
// slave index map and a one-hot to index helper.
package bus_pkg;

  localparam int unsigned AW_DEF      = 16;
  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned SEL_LSB_DEF = 8;

  localparam int unsigned SLV_MEM0 = 0;
  localparam int unsigned SLV_MEM1 = 1;
  localparam int unsigned SLV_ALU  = 2;
  localparam int unsigned SLV_REG  = 3;
  localparam int unsigned SLV_IO   = 4;

  // OR of the positions of all set bits; exact for one-hot inputs up to 16 wide.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with parked owner and optional hold limit.
// Grant is registered and always one-hot; illegal values recover to master 0.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

  logic [N-1:0]  grant_q, grant_d, rot_grant;
  logic [HW-1:0] hold_q, hold_d;
  logic [IW-1:0] owner;
  logic          legal, others, keep;

  assign owner  = IW'(onehot_to_idx(16'(grant_q)));
  assign legal  = (grant_q != '0) && ((grant_q & (grant_q - N'(1))) == '0);
  assign others = |(req & ~grant_q);
  assign keep   = req[owner] && ((MAX_HOLD == 0) || !others || (hold_q < HOLD_LIM));

  // Scan owner+1 .. owner+N so the current owner is considered last.
  always_comb begin
    int unsigned k;
    logic        found;
    rot_grant = '0;
    found     = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = 32'(owner) + i;
      if (k >= N) k = k - N;
      if (!found && req[IW'(k)]) begin
        found               = 1'b1;
        rot_grant[IW'(k)]   = 1'b1;
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    hold_d  = hold_q;
    if (!legal) begin
      grant_d = N'(1);
      hold_d  = '0;
    end else if (req == '0) begin
      hold_d  = '0;
    end else if (keep) begin
      if ((MAX_HOLD != 0) && (hold_q != HOLD_LIM)) hold_d = HW'(hold_q + 1'b1);
    end else begin
      grant_d = rot_grant;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= N'(1);
      hold_q  <= '0;
    end else begin
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: rtl/bus_rr_matrix.sv
// N-master / N-slave shared bus: round-robin arbitration, address-field slave
// decode and a one-cycle registered read-data select.
module bus_rr_matrix
  import bus_pkg::*;
#(
  parameter int unsigned N_MASTER = 4,
  parameter int unsigned N_SLAVE  = 5,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned SEL_LSB  = SEL_LSB_DEF,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_MASTER-1:0]    m_req,
  input  logic [N_MASTER-1:0]    m_wr,
  input  logic [N_MASTER*AW-1:0] m_addr,
  input  logic [N_MASTER*DW-1:0] m_dout,
  input  logic [N_SLAVE*DW-1:0]  s_dout,
  output logic [N_MASTER-1:0]    m_grant,
  output logic [DW-1:0]          m_din,
  output logic [N_SLAVE-1:0]     s_sel,
  output logic [AW-1:0]          s_addr,
  output logic                   s_wr,
  output logic [DW-1:0]          s_din,
  output logic                   dec_err
);

  localparam int unsigned IDXW = AW - SEL_LSB;

  logic [IDXW-1:0]    slv_idx;
  logic [N_SLAVE-1:0] sel_q, sel_d;
  logic               dec_err_q, dec_err_d;

  rr_arbiter #(
    .N        (N_MASTER),
    .MAX_HOLD (MAX_HOLD)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (m_req),
    .grant (m_grant)
  );

  // Owner mux; the owner drives the bus even while parked.
  always_comb begin
    s_addr = '0;
    s_wr   = 1'b0;
    s_din  = '0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      if (m_grant[i]) begin
        s_addr = m_addr[i*AW +: AW];
        s_wr   = m_wr[i];
        s_din  = m_dout[i*DW +: DW];
      end
    end
  end

  assign slv_idx = s_addr[AW-1:SEL_LSB];

  // Out-of-range index selects no slave.
  always_comb begin
    s_sel = '0;
    for (int unsigned j = 0; j < N_SLAVE; j++) begin
      s_sel[j] = (32'(slv_idx) == j);
    end
  end

  assign sel_d     = s_sel;
  assign dec_err_d = (s_sel == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q     <= '0;
      dec_err_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      dec_err_q <= dec_err_d;
    end
  end

  always_comb begin
    m_din = '0;
    for (int unsigned j = 0; j < N_SLAVE; j++) begin
      if (sel_q[j]) m_din = m_din | s_dout[j*DW +: DW];
    end
  end

  assign dec_err = dec_err_q;

endmodule

// File: tb/tb_bus_rr_matrix.sv
// Self-checking bench for bus_rr_matrix: one instance without hold limit, one
// with MAX_HOLD=4, sharing stimulus; read returns checked through a scoreboard.
module tb_bus_rr_matrix;

  localparam int unsigned NM = 4;
  localparam int unsigned NS = 5;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     m_req, m_wr;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_dout;
  logic [NS*DW-1:0]  s_dout;

  logic [NM-1:0] a_grant, b_grant;
  logic [DW-1:0] a_din, b_din, a_sdin, b_sdin;
  logic [NS-1:0] a_sel, b_sel;
  logic [AW-1:0] a_saddr, b_saddr;
  logic          a_swr, b_swr, a_err, b_err;

  typedef struct {
    logic [DW-1:0] din_a;
    logic          err_a;
    logic [DW-1:0] din_b;
    logic          err_b;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   own_a, own_b, hold_b;

  always #5 clk = ~clk;

  bus_rr_matrix #(.N_MASTER(NM), .N_SLAVE(NS), .AW(AW), .DW(DW), .SEL_LSB(8), .MAX_HOLD(0)) dut_a (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .s_dout(s_dout), .m_grant(a_grant), .m_din(a_din), .s_sel(a_sel), .s_addr(a_saddr),
    .s_wr(a_swr), .s_din(a_sdin), .dec_err(a_err));

  bus_rr_matrix #(.N_MASTER(NM), .N_SLAVE(NS), .AW(AW), .DW(DW), .SEL_LSB(8), .MAX_HOLD(4)) dut_b (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .s_dout(s_dout), .m_grant(b_grant), .m_din(b_din), .s_sel(b_sel), .s_addr(b_saddr),
    .s_wr(b_swr), .s_din(b_sdin), .dec_err(b_err));

  // Expected {dec_err, m_din} one cycle after owner `own` presents its address.
  function automatic logic [DW:0] read_of(int own);
    logic [AW-1:0] addr;
    int            idx;
    addr = m_addr[own*AW +: AW];
    idx  = int'(addr[AW-1:8]);
    if (idx < int'(NS)) return {1'b0, s_dout[idx*DW +: DW]};
    return {1'b1, {DW{1'b0}}};
  endfunction

  function automatic int scan(int own, logic [NM-1:0] req);
    for (int i = 1; i <= int'(NM); i++) begin
      if (req[(own + i) % NM]) return (own + i) % NM;
    end
    return own;
  endfunction

  function automatic logic [NS-1:0] sel_of(logic [AW-1:0] addr);
    int idx;
    idx = int'(addr[AW-1:8]);
    if (idx < int'(NS)) return NS'(1) << idx;
    return '0;
  endfunction

  task automatic model_next();
    logic others;
    if (m_req != '0 && !m_req[own_a]) own_a = scan(own_a, m_req);
    others = (m_req & ~(NM'(1) << own_b)) != '0;
    if (m_req == '0) hold_b = 0;
    else if (m_req[own_b] && (!others || hold_b < 3)) begin
      if (hold_b < 3) hold_b++;
    end else begin
      own_b  = scan(own_b, m_req);
      hold_b = 0;
    end
  endtask

  task automatic model_reset();
    own_a = 0; own_b = 0; hold_b = 0;
    sb_q.delete();
  endtask

  // Push the read return implied by current inputs, then advance one edge.
  task automatic tick();
    exp_t        e;
    logic [DW:0] ra, rb;
    ra = read_of(own_a);
    rb = read_of(own_b);
    e.din_a = ra[DW-1:0]; e.err_a = ra[DW];
    e.din_b = rb[DW-1:0]; e.err_b = rb[DW];
    sb_q.push_back(e);
    @(posedge clk);
    model_next();
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; m_req = '0; m_wr = '0; m_addr = '0; m_dout = '0; s_dout = '0;
    for (int j = 1; j < int'(NS); j++) s_dout[j*DW +: DW] = 32'h5500_0000 + 32'(j);
    #1;
    checks++;
    if ({a_grant, b_grant, a_din, b_din, a_err, b_err} !== {4'b0001, 4'b0001, {2*DW{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_async: grant %b/%b din %h/%h err %b/%b, want 0001 0 0", a_grant, b_grant, a_din, b_din, a_err, b_err);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      e = sb_q.pop_front(); checks++;
      if ({a_din, a_err, b_din, b_err} !== {e.din_a, e.err_a, e.din_b, e.err_b}) begin
        errors++;
        $display("FAIL reset_idle_read: got %h/%b %h/%b want %h/%b %h/%b", a_din, a_err, b_din, b_err, e.din_a, e.err_a, e.din_b, e.err_b);
      end
    end
    checks++;
    if ({a_grant, b_grant, a_sel, b_sel, a_saddr, a_din, a_err} !== {4'b0001, 4'b0001, 5'b00001, 5'b00001, 16'h0000, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle: grant %b/%b sel %b/%b addr %h din %h err %b", a_grant, b_grant, a_sel, b_sel, a_saddr, a_din, a_err);
    end
  endtask

  task automatic test_rotate();
    m_req = 4'b1010;
    tick();
    checks++;
    if ({a_grant, b_grant} !== 8'b0010_0010) begin
      errors++; $display("FAIL rotate_first: grant %b/%b want 0010", a_grant, b_grant);
    end
    m_req = 4'b1000;
    tick();
    checks++;
    if ({a_grant, b_grant} !== 8'b1000_1000) begin
      errors++; $display("FAIL rotate_drop: grant %b/%b want 1000", a_grant, b_grant);
    end
    m_req = 4'b0000;
    tick(); tick();
    checks++;
    if ({a_grant, b_grant} !== 8'b1000_1000) begin
      errors++; $display("FAIL rotate_park: grant %b/%b want 1000", a_grant, b_grant);
    end
    sb_q.delete();
  endtask

  task automatic test_hold_limit();
    logic [NM-1:0] want_b;
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    m_req = 4'b0011;
    for (int k = 1; k <= 16; k++) begin
      tick();
      want_b = NM'(1) << ((k / 4) % 2);
      checks++;
      if (b_grant !== want_b || a_grant !== 4'b0001) begin
        errors++;
        $display("FAIL hold_limit cycle %0d: grant a %b b %b want a 0001 b %b", k, a_grant, b_grant, want_b);
      end
    end
    sb_q.delete();
  endtask

  task automatic test_read();
    exp_t e;
    m_req = 4'b0100; m_wr = 4'b0100;
    m_addr[2*AW +: AW] = 16'h0310;
    m_dout[2*DW +: DW] = 32'h1234_5678;
    for (int j = 0; j < int'(NS); j++) s_dout[j*DW +: DW] = 32'hA000_0000 + 32'(j);
    s_dout[3*DW +: DW] = 32'hDEAD_BEEF;
    tick();
    e = sb_q.pop_front(); checks++;
    if ({a_din, a_err, b_din, b_err} !== {e.din_a, e.err_a, e.din_b, e.err_b}) begin
      errors++;
      $display("FAIL read_switch: got %h/%b %h/%b want %h/%b %h/%b", a_din, a_err, b_din, b_err, e.din_a, e.err_a, e.din_b, e.err_b);
    end
    checks++;
    if ({a_grant, b_grant, a_sel, b_sel, a_saddr, a_swr, a_sdin} !== {8'b0100_0100, 5'b01000, 5'b01000, 16'h0310, 1'b1, 32'h1234_5678}) begin
      errors++;
      $display("FAIL read_mux: grant %b/%b sel %b/%b addr %h wr %b din %h", a_grant, b_grant, a_sel, b_sel, a_saddr, a_swr, a_sdin);
    end
    tick();
    e = sb_q.pop_front(); checks++;
    if ({a_din, a_err, b_din, b_err} !== {e.din_a, e.err_a, e.din_b, e.err_b} || {a_din, a_err} !== {32'hDEAD_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL read_data: got %h/%b %h/%b want DEADBEEF/0", a_din, a_err, b_din, b_err);
    end
  endtask

  task automatic test_dec_err();
    exp_t          e;
    logic [AW-1:0] addrs [3];
    logic [DW:0]   want [3];
    addrs = '{16'h0705, 16'h04FF, 16'h0500};
    want  = '{{1'b1, 32'h0}, {1'b0, 32'hA000_0004}, {1'b1, 32'h0}};
    m_wr = '0;
    for (int i = 0; i < 3; i++) begin
      m_addr[2*AW +: AW] = addrs[i];
      #1;
      checks++;
      if (a_sel !== sel_of(addrs[i]) || b_sel !== sel_of(addrs[i])) begin
        errors++; $display("FAIL dec_sel %h: sel %b/%b want %b", addrs[i], a_sel, b_sel, sel_of(addrs[i]));
      end
      tick();
      e = sb_q.pop_front(); checks++;
      if ({a_din, a_err, b_din, b_err} !== {e.din_a, e.err_a, e.din_b, e.err_b} || {a_err, a_din} !== want[i]) begin
        errors++;
        $display("FAIL dec_err %h: got %h/%b %h/%b want %h/%b", addrs[i], a_din, a_err, b_din, b_err, e.din_a, e.err_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t          e;
    logic [AW-1:0] addrs [8];
    logic [NM-1:0] reqs  [8];
    logic [AW-1:0] base;
    addrs = '{16'h0000, 16'h0110, 16'h0705, 16'h0220, 16'h03FF, 16'h0480, 16'hFF00, 16'h0101};
    reqs  = '{4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b1001, 4'b1000, 4'b0110, 4'b0010};
    for (int i = 0; i < 8; i++) begin
      m_req = reqs[i];
      base  = addrs[i];
      for (int m = 0; m < int'(NM); m++) m_addr[m*AW +: AW] = {base[15:8], 8'(m * 16 + i)};
      tick();
      e = sb_q.pop_front(); checks++;
      if ({a_din, a_err, b_din, b_err} !== {e.din_a, e.err_a, e.din_b, e.err_b}) begin
        errors++;
        $display("FAIL b2b step %0d: got %h/%b %h/%b want %h/%b %h/%b", i, a_din, a_err, b_din, b_err, e.din_a, e.err_a, e.din_b, e.err_b);
      end
      checks++;
      if (a_grant !== (NM'(1) << own_a) || b_grant !== (NM'(1) << own_b)) begin
        errors++; $display("FAIL b2b_grant step %0d: grant %b/%b want owners %0d/%0d", i, a_grant, b_grant, own_a, own_b);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    m_req = 4'b1000;
    m_addr[3*AW +: AW] = 16'h0210;
    tick(); void'(sb_q.pop_front());
    tick();
    e = sb_q.pop_front(); checks++;
    if ({a_grant, b_grant} !== 8'b1000_1000 || a_din !== 32'hA000_0002 || a_din !== e.din_a) begin
      errors++; $display("FAIL mid_pre: grant %b/%b din %h want 1000 A0000002", a_grant, b_grant, a_din);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({a_grant, b_grant, a_din, b_din, a_err, b_err} !== {8'b0001_0001, {2*DW{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL mid_reset: grant %b/%b din %h/%h err %b/%b want 0001 0 0", a_grant, b_grant, a_din, b_din, a_err, b_err);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    exp_t e;
    for (int c = 0; c < 300; c++) begin
      m_req = NM'($urandom);
      m_wr  = NM'($urandom);
      for (int m = 0; m < int'(NM); m++) begin
        m_addr[m*AW +: AW] = {8'($urandom_range(0, 7)), 8'($urandom)};
        m_dout[m*DW +: DW] = $urandom;
      end
      for (int j = 0; j < int'(NS); j++) s_dout[j*DW +: DW] = $urandom;
      tick();
      e = sb_q.pop_front(); checks++;
      if ({a_din, a_err, b_din, b_err} !== {e.din_a, e.err_a, e.din_b, e.err_b}) begin
        errors++;
        $display("FAIL rand_read %0d: got %h/%b %h/%b want %h/%b %h/%b", c, a_din, a_err, b_din, b_err, e.din_a, e.err_a, e.din_b, e.err_b);
      end
      checks++;
      if (a_grant !== (NM'(1) << own_a) || b_grant !== (NM'(1) << own_b) ||
          a_saddr !== m_addr[own_a*AW +: AW] || b_sdin !== m_dout[own_b*DW +: DW]) begin
        errors++;
        $display("FAIL rand_grant %0d: grant %b/%b want owners %0d/%0d", c, a_grant, b_grant, own_a, own_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_hold_limit();
    test_read();
    test_dec_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
